// File: rtl/inst_enc_pkg.sv
// Shared constants for the RV32I field-to-word instruction encoder:
// opcodes, request class codes and controller state encodings.
package inst_enc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] CLS_R      = 3'd0;
  localparam logic [2:0] CLS_IMM    = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;

  typedef logic [0:0] state_t;
  localparam state_t ST_ACCEPT = 1'b0;
  localparam state_t ST_FULL   = 1'b1;

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bus of the instruction encoder. The slave modport is the
// encoder's view; the master modport is the request source / word sink view.
interface inst_encoder_if #(parameter int AW = 6);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_cls;
  logic [4:0]         in_rd;
  logic [4:0]         in_rs1;
  logic [4:0]         in_rs2;
  logic [2:0]         in_funct3;
  logic [6:0]         in_funct7;
  logic signed [31:0] in_imm;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_inst;
  logic [AW-1:0]      out_addr;

  modport master (
    output in_valid, in_cls, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr
  );

  modport slave (
    input  in_valid, in_cls, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr
  );
endinterface

// File: rtl/inst_pack.sv
// Combinational packer: turns decoded RV32I fields into an instruction word
// and flags whether the request is encodable (class known, immediate in range).
// Optional B-type support is enabled by defining INST_ENC_BTYPE_EN.
module inst_pack
  import inst_enc_pkg::*;
(
  input  logic [2:0]         cls,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic signed [31:0] imm,
  output logic [31:0]        inst,
  output logic               ok
);

  logic imm12_fits;
  logic shamt_fits;
  logic is_shift;

  // 12-bit signed immediates: imm[31:11] all equal is the same as -2048..2047
  assign imm12_fits = (imm >= -32'sd2048) && (imm <= 32'sd2047);
  assign shamt_fits = (imm >= 32'sd0) && (imm <= 32'sd31);
  assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);

`ifdef INST_ENC_BTYPE_EN
  logic imm13_fits;
  // Branch offsets are even and span -4096..4094
  assign imm13_fits = (imm >= -32'sd4096) && (imm <= 32'sd4094) && !imm[0];
`endif

  // Select the field layout per class and apply that class's range rule
  always_comb begin
    inst = '0;
    ok   = 1'b0;
    case (cls)
      CLS_R: begin
        inst = {funct7, rs2, rs1, funct3, rd, OP_R};
        ok   = 1'b1;
      end
      CLS_IMM: begin
        if (is_shift) begin
          // Shifts carry funct7 in the upper bits and a 5-bit shamt
          inst = {funct7, imm[4:0], rs1, funct3, rd, OP_IMM};
          ok   = shamt_fits;
        end else begin
          inst = {imm[11:0], rs1, funct3, rd, OP_IMM};
          ok   = imm12_fits;
        end
      end
      CLS_LOAD: begin
        inst = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        ok   = imm12_fits;
      end
      CLS_STORE: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        ok   = imm12_fits;
      end
`ifdef INST_ENC_BTYPE_EN
      CLS_BRANCH: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        ok   = imm13_fits;
      end
`else
      CLS_BRANCH: begin
        inst = '0;
        ok   = 1'b0;
      end
`endif
      default: begin
        inst = '0;
        ok   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: accepts decoded fields over valid/ready, packs a
// word, and presents it with a sequential instruction-memory word address.
// Rejected requests pulse err and bump a saturating error count.
// Define INST_ENC_BTYPE_EN to accept the branch class (B-type encoding).
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
)
(
  input  logic           clk,
  input  logic           rst,
  inst_encoder_if.slave  bus,
  input  logic           clear,
  output logic           full,
  output logic           err,
  output logic [7:0]     err_cnt
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic          vld_p1;
  logic [31:0]   inst_p1;
  logic [31:0]   pack_inst;
  logic          pack_ok;
  logic          accept;
  logic          drain;
  logic          reject;
  logic          at_last;

  inst_pack u_pack (
    .cls    (bus.in_cls),
    .rd     (bus.in_rd),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .funct3 (bus.in_funct3),
    .funct7 (bus.in_funct7),
    .imm    (bus.in_imm),
    .inst   (pack_inst),
    .ok     (pack_ok)
  );

  // A new word can enter whenever the output slot is empty or being drained
  assign bus.in_ready = (state == ST_ACCEPT) && (!vld_p1 || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = vld_p1 && bus.out_ready;
  assign reject       = accept && !pack_ok;
  assign at_last      = (wr_ptr == LAST_ADDR);

  assign bus.out_valid = vld_p1;
  assign bus.out_inst  = inst_p1;
  assign bus.out_addr  = wr_ptr;
  assign full          = (state == ST_FULL);

  // Controller: go FULL when the last slot drains; only clear/rst re-opens
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACCEPT;
    end else if (clear) begin
      state <= ST_ACCEPT;
    end else if ((state == ST_ACCEPT) && drain && at_last) begin
      state <= ST_FULL;
    end
  end

  // Word address advances per drained word; it holds at the last slot once full
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
    end else if (drain && !at_last) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // stage p1: registered output word, held until the sink takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      inst_p1 <= '0;
    end else if (accept && pack_ok) begin
      vld_p1  <= 1'b1;
      inst_p1 <= pack_inst;
    end else if (drain) begin
      vld_p1  <= 1'b0;
    end
  end

  // One-cycle error pulse following each rejected request
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= reject;
    end
  end

  // Saturating rejected-request counter, zeroed by clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clear) begin
      err_cnt <= '0;
    end else if (reject) begin
      err_cnt <= sat_inc8(err_cnt);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus a randomized
// stream checked against a field-arithmetic reference model. A second
// instance with DEPTH=4 covers the full/clear/reset and saturation paths.
module tb_inst_encoder;

  logic       clk = 1'b0;
  logic       rst, clear, full, err;
  logic [7:0] err_cnt;
  logic       rst4, clear4, full4, err4;
  logic [7:0] err_cnt4;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  inst_encoder_if #(.AW(6)) bus ();
  inst_encoder_if #(.AW(2)) bus4 ();

  inst_encoder #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clear(clear),
    .full(full), .err(err), .err_cnt(err_cnt)
  );

  inst_encoder #(.DEPTH(4), .AW(2)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4), .clear(clear4),
    .full(full4), .err(err4), .err_cnt(err_cnt4)
  );

  // Reference encoder built from the RV32I field positions with shifts/masks
  function automatic void ref_enc(input int cls, input int rd, input int rs1, input int rs2,
                                  input int f3, input int f7, input int imm,
                                  output bit ok, output logic [31:0] w);
    logic [31:0] u;
    logic [31:0] base;
    u    = imm;
    base = (32'(rs1) << 15) | (32'(f3) << 12);
    ok   = 1'b0;
    w    = 32'h0;
    case (cls)
      0: begin ok = 1'b1; w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7) | 32'h33; end
      1: begin
        if (f3 == 1 || f3 == 5) begin
          ok = (imm >= 0) && (imm <= 31);
          w  = (32'(f7) << 25) | ((u & 32'h1F) << 20) | base | (32'(rd) << 7) | 32'h13;
        end else begin
          ok = (imm >= -2048) && (imm <= 2047);
          w  = ((u & 32'hFFF) << 20) | base | (32'(rd) << 7) | 32'h13;
        end
      end
      2: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = ((u & 32'hFFF) << 20) | base | (32'(rd) << 7) | 32'h03;
      end
      3: begin
        ok = (imm >= -2048) && (imm <= 2047);
        w  = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((u & 32'h1F) << 7) | 32'h23;
      end
`ifdef INST_ENC_BTYPE_EN
      4: begin
        ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
        w  = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | base
           | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
      end
`endif
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int cls, input int rd, input int rs1, input int rs2,
                         input int f3, input int f7, input int imm);
    bus.in_valid  = 1'b1;
    bus.in_cls    = 3'(cls);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_imm    = imm;
  endtask

  task automatic set_req4(input int cls, input int rd, input int imm);
    bus4.in_valid  = 1'b1;
    bus4.in_cls    = 3'(cls);
    bus4.in_rd     = 5'(rd);
    bus4.in_rs1    = 5'd3;
    bus4.in_rs2    = 5'd0;
    bus4.in_funct3 = 3'd0;
    bus4.in_funct7 = 7'd0;
    bus4.in_imm    = imm;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst4 = 1'b1; clear = 1'b0; clear4 = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    set_req4(0, 0, 0); bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0; rst4 = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_inst !== 32'h0) begin bad++; $display("FAIL rst_out_inst got=%h want=0", bus.out_inst); end
    total++; if (bus.out_addr !== 6'd0) begin bad++; $display("FAIL rst_out_addr got=%0d want=0", bus.out_addr); end
    total++; if (full !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_full_err got=%0b%0b want=00", full, err); end
    total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err_cnt got=%0d want=0", err_cnt); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", bus.in_ready); end
    total++; if (bus4.out_valid !== 1'b0 || full4 !== 1'b0) begin bad++; $display("FAIL rst4 got=%0b%0b want=00", bus4.out_valid, full4); end
  endtask

  task automatic test_addi;
    set_req(1, 1, 2, 0, 0, 0, -1);
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_inst !== 32'hFFF10093) begin bad++; $display("FAIL addi_inst got=%h want=fff10093", bus.out_inst); end
    total++; if (bus.out_addr !== 6'd0) begin bad++; $display("FAIL addi_addr got=%0d want=0", bus.out_addr); end
    bus.out_ready = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 6'd1) begin bad++; $display("FAIL addi_drain got=%0b/%0d want=0/1", bus.out_valid, bus.out_addr); end
  endtask

  task automatic test_store_shift_err;
    set_req(3, 0, 10, 5, 2, 0, 8);
    tick();
    total++; if (bus.out_inst !== 32'h00552423 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL sw_inst got=%h/%0b want=00552423/1", bus.out_inst, bus.out_valid); end
    total++; if (bus.out_addr !== 6'd1) begin bad++; $display("FAIL sw_addr got=%0d want=1", bus.out_addr); end
    set_req(1, 1, 2, 0, 1, 0, 33);
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL shamt_no_out got=%0b want=0", bus.out_valid); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL shamt_err got=%0b want=1", err); end
    total++; if (err_cnt !== 8'd1) begin bad++; $display("FAIL shamt_err_cnt got=%0d want=1", err_cnt); end
    total++; if (bus.out_addr !== 6'd2) begin bad++; $display("FAIL shamt_addr got=%0d want=2", bus.out_addr); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_pulse_len got=%0b want=0", err); end
  endtask

  task automatic test_range_back_to_back;
    bit          ok;
    logic [31:0] w;
    set_req(1, 1, 2, 0, 0, 0, 2048);
    tick();
    total++; if (err !== 1'b1 || err_cnt !== 8'd2) begin bad++; $display("FAIL imm2048 got=%0b/%0d want=1/2", err, err_cnt); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL imm2048_no_out got=%0b want=0", bus.out_valid); end
    ref_enc(1, 3, 4, 0, 0, 0, 100, ok, w);
    set_req(1, 3, 4, 0, 0, 0, 100);
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_inst !== w) begin bad++; $display("FAIL b2b_inst got=%h/%0b want=%h/1", bus.out_inst, bus.out_valid, w); end
    total++; if (bus.out_addr !== 6'd2 || err !== 1'b0) begin bad++; $display("FAIL b2b_addr got=%0d/%0b want=2/0", bus.out_addr, err); end
    tick();
  endtask

  task automatic test_backpressure;
    bit          ok;
    logic [31:0] wa, wb;
    ref_enc(2, 7, 8, 0, 2, 0, -2048, ok, wa);
    ref_enc(0, 9, 10, 11, 0, 32, 0, ok, wb);
    bus.out_ready = 1'b0;
    set_req(2, 7, 8, 0, 2, 0, -2048);
    tick();
    set_req(0, 9, 10, 11, 0, 32, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%0b want=0", i, bus.in_ready); end
      total++; if (bus.out_inst !== wa || bus.out_addr !== 6'd3 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h@%0d want=%h@3", i, bus.out_inst, bus.out_addr, wa); end
      if (i < 2) tick();
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b want=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_inst !== wb || bus.out_addr !== 6'd4 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_second got=%h@%0d want=%h@4", bus.out_inst, bus.out_addr, wb); end
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.out_addr !== 6'd5) begin bad++; $display("FAIL bp_done got=%0b@%0d want=0@5", bus.out_valid, bus.out_addr); end
  endtask

  task automatic test_btype;
    bus.out_ready = 1'b1;
    set_req(4, 0, 1, 2, 0, 0, -4);
    tick();
    set_req(4, 0, 1, 2, 0, 0, 3);
`ifdef INST_ENC_BTYPE_EN
    total++; if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'hFE208EE3) begin bad++; $display("FAIL btype_inst got=%h/%0b want=fe208ee3/1", bus.out_inst, bus.out_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL btype_no_err got=%0b want=0", err); end
`else
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL btype_off_no_out got=%0b want=0", bus.out_valid); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL btype_off_err got=%0b want=1", err); end
`endif
    tick();
    bus.in_valid = 1'b0;
    total++; if (err !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL btype_odd got=%0b/%0b want=1/0", err, bus.out_valid); end
    tick();
  endtask

  task automatic test_random_stream;
    bit          pv, ok, iv, ordy, acc, drn;
    logic [31:0] pinst, w;
    int          ptr, ecnt, cls, rd, rs1, rs2, f3, f7, imm;
    bit          eexp;
    int          edges [12] = '{-2049, -2048, 2047, 2048, 31, 32, 0, -1, -4096, 4094, 4095, -4098};
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    pv = 1'b0; ptr = 0; ecnt = 0; eexp = 1'b0; pinst = 32'h0;
    for (int c = 0; c < 60; c++) begin
      total++; if (bus.out_valid !== pv) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", c, bus.out_valid, pv); end
      total++; if (bus.out_addr !== 6'(ptr)) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%0d want=%0d", c, bus.out_addr, ptr); end
      if (pv) begin
        total++; if (bus.out_inst !== pinst) begin bad++; $display("FAIL rnd_inst cyc=%0d got=%h want=%h", c, bus.out_inst, pinst); end
      end
      total++; if (err !== eexp || err_cnt !== 8'(ecnt)) begin bad++; $display("FAIL rnd_err cyc=%0d got=%0b/%0d want=%0b/%0d", c, err, err_cnt, eexp, ecnt); end
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      cls  = $urandom_range(0, 7);
      rd   = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
      f3   = $urandom_range(0, 7);  f7  = $urandom_range(0, 127);
      case ($urandom_range(0, 4))
        0: imm = $urandom;
        1: imm = $urandom_range(0, 4095) - 2048;
        2: imm = edges[$urandom_range(0, 11)];
        3: imm = $urandom_range(0, 40);
        default: imm = 2 * ($urandom_range(0, 4095) - 2048);
      endcase
      set_req(cls, rd, rs1, rs2, f3, f7, imm);
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      #1;
      total++; if (bus.in_ready !== (!pv || ordy)) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%0b want=%0b", c, bus.in_ready, !pv || ordy); end
      acc = iv && (!pv || ordy);
      drn = pv && ordy;
      ref_enc(cls, rd, rs1, rs2, f3, f7, imm, ok, w);
      if (drn) ptr++;
      if (acc && ok) begin pv = 1'b1; pinst = w; end
      else if (drn) pv = 1'b0;
      eexp = acc && !ok;
      if (eexp && ecnt < 255) ecnt++;
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_full_clear;
    bit          ok;
    logic [31:0] w;
    bus4.out_ready = 1'b1;
    set_req4(7, 0, 0);
    tick();
    bus4.in_valid = 1'b0;
    total++; if (err4 !== 1'b1 || err_cnt4 !== 8'd1) begin bad++; $display("FAIL d4_reject got=%0b/%0d want=1/1", err4, err_cnt4); end
    for (int k = 0; k < 4; k++) begin
      set_req4(1, k + 1, 10 * k);
      tick();
      ref_enc(1, k + 1, 3, 0, 0, 0, 10 * k, ok, w);
      total++; if (bus4.out_valid !== 1'b1 || bus4.out_inst !== w || bus4.out_addr !== 2'(k)) begin bad++; $display("FAIL d4_word k=%0d got=%h@%0d want=%h@%0d", k, bus4.out_inst, bus4.out_addr, w, k); end
    end
    bus4.in_valid = 1'b0;
    tick();
    total++; if (full4 !== 1'b1 || bus4.in_ready !== 1'b0) begin bad++; $display("FAIL d4_full got=%0b/%0b want=1/0", full4, bus4.in_ready); end
    total++; if (bus4.out_valid !== 1'b0 || bus4.out_addr !== 2'd3) begin bad++; $display("FAIL d4_full_addr got=%0b@%0d want=0@3", bus4.out_valid, bus4.out_addr); end
    set_req4(1, 5, 5);
    tick();
    bus4.in_valid = 1'b0;
    total++; if (bus4.out_valid !== 1'b0) begin bad++; $display("FAIL d4_blocked got=%0b want=0", bus4.out_valid); end
    clear4 = 1'b1;
    tick();
    clear4 = 1'b0;
    total++; if (full4 !== 1'b0 || bus4.out_addr !== 2'd0 || err_cnt4 !== 8'd0) begin bad++; $display("FAIL d4_clear got=%0b/%0d/%0d want=0/0/0", full4, bus4.out_addr, err_cnt4); end
    total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL d4_clear_ready got=%0b want=1", bus4.in_ready); end
    // drain one word so the pointer moves, then collide clear with a drain
    set_req4(1, 1, 1);
    tick();
    tick();
    total++; if (bus4.out_valid !== 1'b1 || bus4.out_addr !== 2'd1) begin bad++; $display("FAIL d4_pre_collide got=%0b@%0d want=1@1", bus4.out_valid, bus4.out_addr); end
    bus4.in_valid = 1'b0;
    clear4 = 1'b1;
    tick();
    clear4 = 1'b0;
    total++; if (bus4.out_addr !== 2'd0 || bus4.out_valid !== 1'b0) begin bad++; $display("FAIL d4_clear_wins got=%0d/%0b want=0/0", bus4.out_addr, bus4.out_valid); end
    bus4.out_ready = 1'b0;
    set_req4(1, 2, 2);
    tick();
    bus4.in_valid = 1'b0;
    total++; if (bus4.out_valid !== 1'b1) begin bad++; $display("FAIL d4_pending got=%0b want=1", bus4.out_valid); end
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    total++; if (bus4.out_valid !== 1'b0 || bus4.out_inst !== 32'h0) begin bad++; $display("FAIL d4_rst_discard got=%0b/%h want=0/0", bus4.out_valid, bus4.out_inst); end
  endtask

  task automatic test_err_saturation;
    bus4.out_ready = 1'b1;
    set_req4(6, 0, 0);
    repeat (260) tick();
    total++; if (err_cnt4 !== 8'd255 || err4 !== 1'b1) begin bad++; $display("FAIL sat_cnt got=%0d/%0b want=255/1", err_cnt4, err4); end
    bus4.in_valid = 1'b0;
    tick();
    total++; if (err_cnt4 !== 8'd255 || err4 !== 1'b0) begin bad++; $display("FAIL sat_hold got=%0d/%0b want=255/0", err_cnt4, err4); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store_shift_err();
    test_range_back_to_back();
    test_backpressure();
    test_btype();
    test_random_stream();
    test_full_clear();
    test_err_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
